// File: rtl/arya_pkg.sv
// Shared types and helpers for the Arya host memory port: FSM states, default
// widths and the bank-slice offset helper used to pick a bank out of mem_rdata.
package arya_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_RD_HOLD
  } state_e;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 64;
  localparam int LEN_W_DEF  = 8;

  function automatic int unsigned bank_lsb(input int unsigned bank, input int unsigned data_w);
    return bank * data_w;
  endfunction

endpackage

// File: rtl/arya_rd_lat_pipe.sv
// Valid-token delay line: a read strobe entering at tok_i emerges at tok_o exactly
// RD_LAT cycles later, marking the cycle in which mem_rdata holds the read word.
module arya_rd_lat_pipe #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic tok_i,
  output logic tok_o
);

  logic [RD_LAT-1:0] sr_q;

  always_ff @(posedge clk) begin
    if (reset) sr_q <= '0;
    else       sr_q <= (sr_q << 1) | RD_LAT'(tok_i);
  end

  assign tok_o = sr_q[RD_LAT-1];

endmodule

// File: rtl/arya_host_mem_port.sv
// Host/debug access port: handshaked read and write bursts into per-core local
// memory banks, holding the target core halted while a session or burst is active.
module arya_host_mem_port
  import arya_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int LEN_W     = LEN_W_DEF,
  parameter int RD_LAT    = 1,
  localparam int CORE_W   = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          debug_on,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [CORE_W-1:0]             cmd_core,
  input  logic [ADDR_W-1:0]             cmd_addr,
  input  logic [LEN_W-1:0]              cmd_len,
  output logic                          cmd_err,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [DATA_W-1:0]             wr_data,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          busy,
  output logic [NUM_CORES-1:0]          core_halt,
  output logic [NUM_CORES-1:0]          mem_en,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [NUM_CORES*DATA_W-1:0]   mem_rdata
);

  localparam int CNT_W = LEN_W + 1;

  state_e                state_q;
  logic [CORE_W-1:0]     core_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  busy_q, cmd_ready_q, cmd_err_q, wr_ready_q, rd_valid_q, mem_we_q;
  logic [DATA_W-1:0]     rd_data_q, mem_wdata_q;
  logic [NUM_CORES-1:0]  mem_en_q, core_halt_q;
  logic [ADDR_W-1:0]     mem_addr_q;

  logic                  cmd_hs, wr_hs, cmd_bad, rd_tok, lat_vld;
  logic [ADDR_W-1:0]     addr_inc;
  logic [CNT_W-1:0]      cnt_dec;
  logic [DATA_W-1:0]     bank_rdata [NUM_CORES];

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_bank
    assign bank_rdata[g] = mem_rdata[bank_lsb(g, DATA_W) +: DATA_W];
  end

  assign cmd_hs   = cmd_valid & cmd_ready_q;
  assign wr_hs    = wr_valid & wr_ready_q;
  assign cmd_bad  = ~debug_on | (32'(cmd_core) >= NUM_CORES);
  assign addr_inc = addr_q + ADDR_W'(1);
  assign cnt_dec  = cnt_q - CNT_W'(1);
  assign rd_tok   = (|mem_en_q) & ~mem_we_q;

  arya_rd_lat_pipe #(.RD_LAT(RD_LAT)) u_lat (
    .clk   (clk),
    .reset (reset),
    .tok_i (rd_tok),
    .tok_o (lat_vld)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b0;
      cmd_err_q   <= 1'b0;
      wr_ready_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      mem_en_q    <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      core_halt_q <= '0;
    end else begin
      mem_en_q  <= '0;
      mem_we_q  <= 1'b0;
      cmd_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_hs) begin
            if (cmd_bad) begin
              cmd_err_q <= 1'b1;
            end else begin
              core_q      <= cmd_core;
              addr_q      <= cmd_addr;
              cnt_q       <= CNT_W'(cmd_len) + CNT_W'(1);
              busy_q      <= 1'b1;
              cmd_ready_q <= 1'b0;
              if (cmd_write) begin
                state_q    <= ST_WR;
                wr_ready_q <= 1'b1;
              end else begin
                state_q    <= ST_RD_ISSUE;
                mem_en_q   <= NUM_CORES'(1) << cmd_core;
                mem_addr_q <= cmd_addr;
              end
            end
          end
        end
        ST_WR: begin
          if (wr_hs) begin
            mem_en_q    <= NUM_CORES'(1) << core_q;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= addr_q;
            mem_wdata_q <= wr_data;
            addr_q      <= addr_inc;
            cnt_q       <= cnt_dec;
            if (cnt_q == CNT_W'(1)) wr_ready_q <= 1'b0;
          end else if (cnt_q == '0) begin
            // Last strobe has been driven; only now release the port.
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
          end
        end
        ST_RD_ISSUE: state_q <= ST_RD_WAIT;
        ST_RD_WAIT: begin
          if (lat_vld) begin
            rd_data_q  <= bank_rdata[core_q];
            rd_valid_q <= 1'b1;
            state_q    <= ST_RD_HOLD;
          end
        end
        ST_RD_HOLD: begin
          if (rd_ready) begin
            rd_valid_q <= 1'b0;
            addr_q     <= addr_inc;
            cnt_q      <= cnt_dec;
            if (cnt_q != CNT_W'(1)) begin
              state_q    <= ST_RD_ISSUE;
              mem_en_q   <= NUM_CORES'(1) << core_q;
              mem_addr_q <= addr_inc;
            end else begin
              state_q     <= ST_IDLE;
              busy_q      <= 1'b0;
              cmd_ready_q <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      for (int i = 0; i < NUM_CORES; i++) begin
        core_halt_q[i] <= debug_on | (busy_q & (core_q == CORE_W'(i)));
      end
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign cmd_err   = cmd_err_q;
  assign wr_ready  = wr_ready_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign busy      = busy_q;
  assign core_halt = core_halt_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_arya_host_mem_port.sv
// Directed plus randomized bench for arya_host_mem_port against a word-level
// memory model and an expected-strobe list.
module tb_arya_host_mem_port;

  localparam int NC = 5;
  localparam int AW = 10;
  localparam int DW = 64;
  localparam int LW = 8;
  localparam int RL = 3;
  localparam int CW = 3;
  localparam int DEPTH = 1 << AW;

  logic            clk, reset, debug_on;
  logic            cmd_valid, cmd_ready, cmd_write, cmd_err;
  logic [CW-1:0]   cmd_core;
  logic [AW-1:0]   cmd_addr;
  logic [LW-1:0]   cmd_len;
  logic            wr_valid, wr_ready, rd_valid, rd_ready, busy, mem_we;
  logic [DW-1:0]   wr_data, rd_data, mem_wdata;
  logic [NC-1:0]   core_halt, mem_en;
  logic [AW-1:0]   mem_addr;
  logic [NC*DW-1:0] mem_rdata;

  arya_host_mem_port #(
    .NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .RD_LAT(RL)
  ) dut (
    .clk(clk), .reset(reset), .debug_on(debug_on),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_core(cmd_core), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_err(cmd_err),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .busy(busy), .core_halt(core_halt),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Bank memories seen by the DUT, with an RL-cycle read pipeline
  logic [DW-1:0] bmem [NC][DEPTH];
  logic [DW-1:0] rp_d [RL];
  int            rp_b [RL];

  function automatic int oh2i(input logic [NC-1:0] v);
    for (int i = 0; i < NC; i++) if (v[i]) return i;
    return 0;
  endfunction

  always @(posedge clk) begin
    if (|mem_en && mem_we) bmem[oh2i(mem_en)][mem_addr] <= mem_wdata;
    rp_d[0] <= (|mem_en && !mem_we) ? bmem[oh2i(mem_en)][mem_addr] : {$urandom, $urandom};
    rp_b[0] <= oh2i(mem_en);
    for (int i = 1; i < RL; i++) begin
      rp_d[i] <= rp_d[i-1];
      rp_b[i] <= rp_b[i-1];
    end
  end

  always_comb begin
    mem_rdata = '0;
    for (int j = 0; j < NC; j++)
      mem_rdata[j*DW +: DW] = (j == rp_b[RL-1]) ? rp_d[RL-1] : ~rp_d[RL-1];
  end

  // Strobe monitor
  typedef struct {
    logic [NC-1:0] en;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    int            cyc;
  } strb_t;

  strb_t obs_q[$];
  strb_t exp_q[$];
  int    obs_base = 0;
  int    cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (|mem_en) begin
      strb_t s;
      s.en = mem_en; s.we = mem_we; s.addr = mem_addr; s.wd = mem_wdata; s.cyc = cyc;
      obs_q.push_back(s);
    end
  end

  // Reference model: plain word arrays indexed by bank and address
  logic [DW-1:0] ref_mem [NC][DEPTH];

  task automatic expect_strobe(input int core, input int addr, input bit we, input logic [DW-1:0] d);
    strb_t s;
    s.en = NC'(1 << core); s.we = we; s.addr = AW'(addr % DEPTH); s.wd = d; s.cyc = 0;
    exp_q.push_back(s);
  endtask

  task automatic check_strobes(input string tag, input bit consec);
    int n_obs;
    n_obs = obs_q.size() - obs_base;
    chk({tag, "_count"}, 64'(n_obs), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < n_obs; i++) begin
      strb_t o;
      o = obs_q[obs_base + i];
      chk({tag, "_en"}, 64'(o.en), 64'(exp_q[i].en));
      chk({tag, "_we"}, 64'(o.we), 64'(exp_q[i].we));
      chk({tag, "_addr"}, 64'(o.addr), 64'(exp_q[i].addr));
      if (exp_q[i].we) chk({tag, "_wdata"}, o.wd, exp_q[i].wd);
      if (consec) chk({tag, "_consec"}, 64'(o.cyc - obs_q[obs_base].cyc), 64'(i));
    end
    obs_base = obs_q.size();
    exp_q.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'(0));
    chk({tag, "_cmd_err"},   64'(cmd_err),   64'(0));
    chk({tag, "_wr_ready"},  64'(wr_ready),  64'(0));
    chk({tag, "_rd_valid"},  64'(rd_valid),  64'(0));
    chk({tag, "_busy"},      64'(busy),      64'(0));
    chk({tag, "_core_halt"}, 64'(core_halt), 64'(0));
    chk({tag, "_mem_en"},    64'(mem_en),    64'(0));
    chk({tag, "_mem_we"},    64'(mem_we),    64'(0));
    chk({tag, "_mem_addr"},  64'(mem_addr),  64'(0));
    chk({tag, "_mem_wdata"}, mem_wdata,      64'(0));
    chk({tag, "_rd_data"},   rd_data,        64'(0));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin @(negedge clk); n++; end
    chk("busy_clear_wait", 64'(busy), 64'(0));
  endtask

  task automatic send_cmd(input bit wr, input int core, input int addr, input int len);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    chk("cmd_ready_wait", 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1; cmd_write = wr;
    cmd_core = CW'(core); cmd_addr = AW'(addr); cmd_len = LW'(len);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("cmd_accept_busy", 64'(busy), 64'(1));
    chk("cmd_accept_ready_low", 64'(cmd_ready), 64'(0));
  endtask

  task automatic do_write(input int core, input int addr, input int len, input bit gaps);
    logic [DW-1:0] d;
    int n;
    send_cmd(1'b1, core, addr, len);
    for (int k = 0; k <= len; k++) begin
      d = {$urandom, $urandom};
      ref_mem[core][(addr + k) % DEPTH] = d;
      expect_strobe(core, addr + k, 1'b1, d);
      if (gaps && $urandom_range(0, 2) == 0) begin
        wr_valid = 1'b0;
        @(negedge clk);
      end
      wr_valid = 1'b1; wr_data = d;
      n = 0;
      while (!wr_ready && n < 20) begin @(negedge clk); n++; end
      chk("wr_ready_wait", 64'(wr_ready), 64'(1));
      @(negedge clk);
    end
    wr_valid = 1'b0;
    wait_idle();
  endtask

  task automatic do_read(input int core, input int addr, input int len, input int hold_mode,
                         input int drop_after, input bit halt_chk);
    logic [DW-1:0] e;
    int n, hold;
    send_cmd(1'b0, core, addr, len);
    for (int k = 0; k <= len; k++) begin
      e = ref_mem[core][(addr + k) % DEPTH];
      expect_strobe(core, addr + k, 1'b0, '0);
      n = 0;
      while (!rd_valid && n < 30) begin
        if (halt_chk) chk("halt_hold", 64'(core_halt[core]), 64'(1));
        @(negedge clk); n++;
      end
      chk("rd_valid_wait", 64'(rd_valid), 64'(1));
      hold = (hold_mode < 0) ? int'($urandom_range(0, 2)) : hold_mode;
      for (int h = 0; h < hold; h++) begin
        rd_ready = 1'b0;
        @(negedge clk);
        chk("rd_hold_valid", 64'(rd_valid), 64'(1));
        chk("rd_hold_data", rd_data, e);
      end
      chk("rd_data", rd_data, e);
      rd_ready = 1'b1;
      @(negedge clk);
      rd_ready = 1'b0;
      if (halt_chk) chk("halt_hold", 64'(core_halt[core]), 64'(1));
      if (k == drop_after) debug_on = 1'b0;
    end
    wait_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int core, addr, len;
    reset = 1'b1; debug_on = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_core = '0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("post_reset_halt", 64'(core_halt), 64'(0));
    debug_on = 1'b1;
    @(negedge clk);
    chk("halt_on_debug", 64'(core_halt), 64'({NC{1'b1}}));

    // 1: write burst core 2, addr 0x010, 4 beats
    do_write(2, 'h010, 3, 1'b0);
    check_strobes("t1", 1'b1);

    // 2: read it back with rd_ready held low one cycle per beat
    do_read(2, 'h010, 3, 1, -1, 1'b0);
    check_strobes("t2", 1'b0);

    // 3: rejected commands
    debug_on = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_core = 3'd2; cmd_addr = '0; cmd_len = '0;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("t3_dbg_err", 64'(cmd_err), 64'(1));
    chk("t3_dbg_busy", 64'(busy), 64'(0));
    chk("t3_dbg_ready", 64'(cmd_ready), 64'(1));
    chk("t3_dbg_wr_ready", 64'(wr_ready), 64'(0));
    @(negedge clk);
    chk("t3_dbg_err_pulse", 64'(cmd_err), 64'(0));
    chk("t3_dbg_mem_en", 64'(mem_en), 64'(0));
    debug_on = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_core = 3'd5;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("t3_core_err", 64'(cmd_err), 64'(1));
    chk("t3_core_busy", 64'(busy), 64'(0));
    chk("t3_core_ready", 64'(cmd_ready), 64'(1));
    @(negedge clk);
    chk("t3_core_err_pulse", 64'(cmd_err), 64'(0));
    chk("t3_core_mem_en", 64'(mem_en), 64'(0));
    repeat (RL + 1) @(negedge clk);
    chk("t3_no_rd_valid", 64'(rd_valid), 64'(0));
    check_strobes("t3", 1'b0);

    // 4: address wrap within a bank
    do_write(0, 'h3FE, 2, 1'b0);
    check_strobes("t4", 1'b1);
    do_read(0, 'h3FE, 2, -1, -1, 1'b0);
    check_strobes("t4rd", 1'b0);

    // 5: debug_on drops after beat 1 of a 4-beat read
    do_write(1, 'h100, 3, 1'b1);
    check_strobes("t5wr", 1'b0);
    do_read(1, 'h100, 3, -1, 0, 1'b1);
    check_strobes("t5rd", 1'b0);
    chk("t5_busy_low", 64'(busy), 64'(0));
    @(negedge clk);
    chk("t5_halt_released", 64'(core_halt), 64'(0));
    debug_on = 1'b1;

    // 6: reset while waiting on read latency
    send_cmd(1'b0, 2, 'h011, 3);
    chk("t6_strobe", 64'(mem_en), 64'(5'b00100));
    @(negedge clk);
    reset = 1'b1;
    obs_base = obs_q.size();
    repeat (2) @(negedge clk);
    chk_all_zero("t6_reset");
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t6_no_rd_valid", 64'(rd_valid), 64'(0));
    end
    check_strobes("t6_quiet", 1'b0);
    do_read(2, 'h011, 1, -1, -1, 1'b0);
    check_strobes("t6_after", 1'b0);

    // Randomized bursts
    for (int r = 0; r < 6; r++) begin
      core = int'($urandom_range(0, NC - 1));
      addr = int'($urandom_range(0, DEPTH - 1));
      len  = int'($urandom_range(0, 5));
      do_write(core, addr, len, 1'b1);
      check_strobes("rnd_wr", 1'b0);
      do_read(core, addr, len, -1, -1, 1'b0);
      check_strobes("rnd_rd", 1'b0);
    end

    // Maximum length: cmd_len all ones gives 256 beats
    addr = int'($urandom_range(0, DEPTH - 1));
    do_write(3, addr, 255, 1'b0);
    check_strobes("long", 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
